shift_add_mult_seq: RTL and testbench
=====================================

Name: shift_add_mult_seq

Overview:
- Sequential unsigned shift-and-add multiplier.
- One WIDTH-bit ripple-carry adder, built from full-adder cells with carry-in tied 0, is reused across WIDTH iterations instead of an array of adders.
- A small controller FSM sequences the adder, accumulator and shift registers.
- Sits beside the combinational multiplier cells as the area-cheap alternative for wider operands.

Parameters:
- WIDTH, 4, operand width in bits (≥2); product is 2*WIDTH bits.
- CNTW, $clog2(WIDTH+1), iteration counter width (derived; do not override).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request pulse; sampled only in IDLE.
- a  input  WIDTH  multiplicand; captured on accepted start.
- b  input  WIDTH  multiplier; captured on accepted start.
- busy  output  1  high in RUN (and DONE); low in IDLE.
- done  output  1  one-cycle pulse; p valid in that cycle.
- p  output  2*WIDTH  product; holds until next accepted start completes.

Behaviour:
- Reset (rst_n=0, async):
  - state=IDLE; busy=0, done=0, p=0.
  - Internal mcand, acc, mplier and count cleared.
- States: IDLE, RUN, DONE.
- IDLE:
  - start=1 at a rising edge: mcand<=a, mplier<=b, acc<=0, count<=0, go to RUN.
  - start=0: remain in IDLE.
- RUN, each edge:
  - sum = acc + (mplier[0] ? mcand : 0) through the shared adder, giving WIDTH bits plus carry-out c.
  - {acc, mplier} <= {c, sum, mplier} >> 1, i.e. a (2*WIDTH+1)-bit right shift that drops mplier[0].
  - count <= count+1.
  - On the edge where count==WIDTH-1 goes to DONE, with p <= the post-shift {acc, mplier}.
- DONE:
  - done=1 and busy=1 for exactly one cycle.
  - Next edge: go to IDLE unconditionally.
- Latency:
  - start sampled at edge k; done high during the cycle after edge k+WIDTH (WIDTH+1 cycles after the start cycle).
  - Minimum start-to-start interval is WIDTH+2 cycles.
- start while busy (RUN or DONE): ignored. No queueing, and operands on a/b are not sampled.
- a/b may change freely after the accepting edge; the operation uses the captured values.
- Arithmetic:
  - Unsigned. Product is exact; 2*WIDTH bits never overflow.
  - The carry-out of each add is folded into the shift and never lost.
- p is only written on entry to DONE. Between operations it holds the last product (0 after reset).
- Reset mid-operation (RUN or DONE): immediately IDLE, busy=0, done=0, p=0. The partial result is discarded.
- done and busy are registered outputs, not decoded from combinational inputs.

Optional Feature:
- Macro: ZERO_SKIP_EN.
- Defined:
  - On an accepted start with a==0 or b==0, go directly IDLE→DONE with p<=0.
  - done is then high in the cycle after the start edge (latency 1).
  - Nonzero operands behave exactly as without the macro.
- Undefined: zero operands take the full WIDTH-iteration RUN path and produce p=0 after WIDTH+1 cycles.

Test Plan (WIDTH=4):
- Basic product: start with a=13, b=11 → busy high next cycle; done one-cycle pulse after 5 cycles; p=143; p still 143 ten cycles later.
- Maximum operands: a=15, b=15 → p=225; checks the carry-out fold on every iteration. Exhaustive sweep of all 256 pairs gives p==a*b each time.
- Zero operand: a=0, b=9 →
  - ZERO_SKIP_EN undefined: done at cycle 5, p=0.
  - ZERO_SKIP_EN defined: done at cycle 1, p=0, busy high only in the DONE cycle.
- start ignored while busy: a=3, b=5 accepted, then start with a=7, b=7 pulsed during RUN and during DONE → single done, p=15, no second operation.
- Reset mid-operation: a=9, b=6 started, rst_n low for 1 cycle at RUN cycle 2 → busy=0, done=0, p=0 immediately (asynchronous); a new start with a=2, b=3 after reset → p=6.
- Back-to-back: second start asserted in the first IDLE cycle after done (a=12, b=10 after a=5, b=4) → done pulses at cycles 5 and 11; p=20, then 120.

Source files
------------

// File: rtl/shift_add_mult_seq.sv
// Sequential unsigned shift-and-add multiplier reusing one WIDTH-bit ripple-carry adder.
// Optional macro ZERO_SKIP_EN: zero operands bypass the iteration loop and finish in one cycle.
module shift_add_mult_seq #(
    parameter  int WIDTH = 4,
    localparam int CNTW  = $clog2(WIDTH + 1)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   p
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t               r_state;
    logic [WIDTH-1:0]     r_mcand;
    logic [WIDTH-1:0]     r_acc;
    logic [WIDTH-1:0]     r_mplier;
    logic [CNTW-1:0]      r_count;
    logic [2*WIDTH-1:0]   r_p;
    logic                 r_busy;
    logic                 r_done;

    logic [WIDTH-1:0]     w_addend;
    logic [WIDTH-1:0]     w_sum;
    logic [WIDTH:0]       w_carry;
    logic                 w_cout;
    logic                 w_lastIter;
    logic                 w_zeroSkip;

    // Shared adder: a chain of full-adder cells with carry-in tied low.
    assign w_addend   = r_mplier[0] ? r_mcand : '0;
    assign w_carry[0] = 1'b0;

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_fa
            assign w_sum[gi]       = r_acc[gi] ^ w_addend[gi] ^ w_carry[gi];
            assign w_carry[gi + 1] = (r_acc[gi] & w_addend[gi]) |
                                     (w_carry[gi] & (r_acc[gi] ^ w_addend[gi]));
        end
    endgenerate

    assign w_cout     = w_carry[WIDTH];
    assign w_lastIter = (r_count == CNTW'(WIDTH - 1));

`ifdef ZERO_SKIP_EN
    assign w_zeroSkip = (a == '0) || (b == '0);
`else
    assign w_zeroSkip = 1'b0;
`endif

    // Carry-out is shifted into acc's MSB so no product bit is ever dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_mcand  <= '0;
            r_acc    <= '0;
            r_mplier <= '0;
            r_count  <= '0;
            r_p      <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        if (w_zeroSkip) begin
                            r_state <= DONE;
                            r_p     <= '0;
                            r_busy  <= 1'b1;
                            r_done  <= 1'b1;
                        end else begin
                            r_state  <= RUN;
                            r_mcand  <= a;
                            r_mplier <= b;
                            r_acc    <= '0;
                            r_count  <= '0;
                            r_busy   <= 1'b1;
                        end
                    end else begin
                        r_busy <= 1'b0;
                    end
                end
                RUN: begin
                    r_acc    <= {w_cout, w_sum[WIDTH-1:1]};
                    r_mplier <= {w_sum[0], r_mplier[WIDTH-1:1]};
                    r_count  <= r_count + CNTW'(1);
                    if (w_lastIter) begin
                        r_state <= DONE;
                        r_p     <= {w_cout, w_sum, r_mplier[WIDTH-1:1]};
                        r_done  <= 1'b1;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign p    = r_p;

endmodule

// File: tb/tb_shift_add_mult_seq.sv
// Directed testbench for shift_add_mult_seq at WIDTH=4; honours ZERO_SKIP_EN when defined.
module tb_shift_add_mult_seq;

    localparam int WIDTH = 4;

    logic             clk;
    logic             rstN;
    logic             start;
    logic [WIDTH-1:0] opA;
    logic [WIDTH-1:0] opB;
    logic             busy;
    logic             done;
    logic [7:0]       prod;

    int compared;
    int mismatched;

    shift_add_mult_seq #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rstN),
        .start (start),
        .a     (opA),
        .b     (opB),
        .busy  (busy),
        .done  (done),
        .p     (prod)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drives a one-cycle start from a negedge; returns at the negedge of cycle 1 after acceptance.
    task automatic pulseStart(input logic [3:0] va, input logic [3:0] vb);
        opA   = va;
        opB   = vb;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        opA   = $urandom_range(15, 0);
        opB   = $urandom_range(15, 0);
    endtask

    // Counts cycles after the accepting edge until done is seen; -1 when it never arrives.
    task automatic waitDone(input int firstCycle, output int cycles);
        cycles = -1;
        for (int i = firstCycle; i <= 30; i++) begin
            if (done === 1'b1) begin
                cycles = i;
                return;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rstN  = 1'b0;
        start = 1'b1;
        opA   = 4'd7;
        opB   = 4'd9;
        repeat (2) @(negedge clk);
        compared++;
        if (busy !== 1'b0 || done !== 1'b0 || prod !== 8'd0) begin
            mismatched++;
            $display("[TB] FAIL reset_state: busy=%b done=%b p=%0d, required 0 0 0", busy, done, prod);
        end
        start = 1'b0;
        rstN  = 1'b1;
        @(negedge clk);
        compared++;
        if (busy !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL reset_idle: busy=%b, required 0", busy);
        end
    endtask

    task automatic test_basic();
        int cyc;
        pulseStart(4'd13, 4'd11);
        compared++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL basic_busy: busy=%b done=%b, required 1 0", busy, done);
        end
        waitDone(1, cyc);
        compared++;
        if (cyc !== 5) begin
            mismatched++;
            $display("[TB] FAIL basic_latency: cycles=%0d, required 5", cyc);
        end
        compared++;
        if (prod !== 8'd143) begin
            mismatched++;
            $display("[TB] FAIL basic_product: p=%0d, required 143", prod);
        end
        @(negedge clk);
        compared++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL basic_pulse: done=%b busy=%b, required 0 0", done, busy);
        end
        repeat (10) @(negedge clk);
        compared++;
        if (prod !== 8'd143) begin
            mismatched++;
            $display("[TB] FAIL basic_hold: p=%0d, required 143", prod);
        end
    endtask

    task automatic test_zero();
        int cyc;
        int expCyc;
`ifdef ZERO_SKIP_EN
        expCyc = 1;
`else
        expCyc = 5;
`endif
        pulseStart(4'd0, 4'd9);
        compared++;
        if (busy !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL zero_busy: busy=%b, required 1", busy);
        end
        waitDone(1, cyc);
        compared++;
        if (cyc !== expCyc) begin
            mismatched++;
            $display("[TB] FAIL zero_latency: cycles=%0d, required %0d", cyc, expCyc);
        end
        compared++;
        if (prod !== 8'd0) begin
            mismatched++;
            $display("[TB] FAIL zero_product: p=%0d, required 0", prod);
        end
        @(negedge clk);
        compared++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL zero_after: busy=%b done=%b, required 0 0", busy, done);
        end
    endtask

    task automatic test_max();
        int cyc;
        pulseStart(4'd15, 4'd15);
        waitDone(1, cyc);
        compared++;
        if (cyc !== 5 || prod !== 8'd225) begin
            mismatched++;
            $display("[TB] FAIL max_product: cycles=%0d p=%0d, required 5 225", cyc, prod);
        end
        @(negedge clk);
    endtask

    task automatic test_exhaustive();
        int cyc;
        int expCyc;
        logic [7:0] expP;
        for (int i = 0; i < 16; i++) begin
            for (int j = 0; j < 16; j++) begin
                expP = 8'(i * j);
`ifdef ZERO_SKIP_EN
                expCyc = (i == 0 || j == 0) ? 1 : 5;
`else
                expCyc = 5;
`endif
                pulseStart(4'(i), 4'(j));
                waitDone(1, cyc);
                compared++;
                if (cyc !== expCyc || prod !== expP) begin
                    mismatched++;
                    $display("[TB] FAIL sweep_%0dx%0d: cycles=%0d p=%0d, required %0d %0d",
                             i, j, cyc, prod, expCyc, expP);
                end
                @(negedge clk);
            end
        end
    endtask

    task automatic test_ignore_busy();
        int cyc;
        int extra;
        pulseStart(4'd3, 4'd5);
        @(negedge clk);
        opA   = 4'd7;
        opB   = 4'd7;
        start = 1'b1;
        waitDone(2, cyc);
        compared++;
        if (cyc !== 5 || prod !== 8'd15) begin
            mismatched++;
            $display("[TB] FAIL ignore_first: cycles=%0d p=%0d, required 5 15", cyc, prod);
        end
        @(negedge clk);
        start = 1'b0;
        extra = 0;
        for (int i = 0; i < 10; i++) begin
            if (done === 1'b1 || busy === 1'b1) extra++;
            @(negedge clk);
        end
        compared++;
        if (extra !== 0 || prod !== 8'd15) begin
            mismatched++;
            $display("[TB] FAIL ignore_second: active_cycles=%0d p=%0d, required 0 15", extra, prod);
        end
    endtask

    task automatic test_reset_mid();
        int cyc;
        pulseStart(4'd9, 4'd6);
        @(negedge clk);
        rstN = 1'b0;
        #1;
        compared++;
        if (busy !== 1'b0 || done !== 1'b0 || prod !== 8'd0) begin
            mismatched++;
            $display("[TB] FAIL reset_mid: busy=%b done=%b p=%0d, required 0 0 0", busy, done, prod);
        end
        @(negedge clk);
        rstN = 1'b1;
        @(negedge clk);
        pulseStart(4'd2, 4'd3);
        waitDone(1, cyc);
        compared++;
        if (cyc !== 5 || prod !== 8'd6) begin
            mismatched++;
            $display("[TB] FAIL reset_restart: cycles=%0d p=%0d, required 5 6", cyc, prod);
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int cyc;
        int cyc2;
        pulseStart(4'd5, 4'd4);
        waitDone(1, cyc);
        compared++;
        if (cyc !== 5 || prod !== 8'd20) begin
            mismatched++;
            $display("[TB] FAIL b2b_first: cycles=%0d p=%0d, required 5 20", cyc, prod);
        end
        @(negedge clk);
        pulseStart(4'd12, 4'd10);
        waitDone(7, cyc2);
        compared++;
        if (cyc2 !== 11 || prod !== 8'd120) begin
            mismatched++;
            $display("[TB] FAIL b2b_second: cycle=%0d p=%0d, required 11 120", cyc2, prod);
        end
        @(negedge clk);
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        start      = 1'b0;
        opA        = '0;
        opB        = '0;
        rstN       = 1'b0;
        @(negedge clk);
        test_reset();
        test_basic();
        test_zero();
        test_max();
        test_ignore_busy();
        test_reset_mid();
        test_back_to_back();
        test_exhaustive();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
